// File: rtl/alu_dispatch_if.sv
// ---------------------------------------------------------------------------
// alu_dispatch_if
//   Bundles the instruction handshake, the decoded-field bus towards the ALU
//   selector, and the ALU completion/status lines of alu_dispatch.
//   master : the dispatcher (drives ready, strobe, fields and status)
//   slave  : the environment (fetch/decode upstream plus the ALU side)
//   Optional build macro: ALU_DISPATCH_TIMEOUT_EN adds the timeout line.
// ---------------------------------------------------------------------------
interface alu_dispatch_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        enable;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        issue_valid;
  logic        alu_done;
  logic        illegal;
  logic        busy;
`ifdef ALU_DISPATCH_TIMEOUT_EN
  logic        timeout;

  modport master (
    input  instr_valid, instr, alu_done,
    output instr_ready, enable, funct7, funct3, rs1, rs2, rd,
    output issue_valid, illegal, busy, timeout
  );

  modport slave (
    output instr_valid, instr, alu_done,
    input  instr_ready, enable, funct7, funct3, rs1, rs2, rd,
    input  issue_valid, illegal, busy, timeout
  );
`else
  modport master (
    input  instr_valid, instr, alu_done,
    output instr_ready, enable, funct7, funct3, rs1, rs2, rd,
    output issue_valid, illegal, busy
  );

  modport slave (
    output instr_valid, instr, alu_done,
    input  instr_ready, enable, funct7, funct3, rs1, rs2, rd,
    input  issue_valid, illegal, busy
  );
`endif
endinterface

// File: rtl/alu_dispatch.sv
// ---------------------------------------------------------------------------
// alu_dispatch
//   Issue-side sequencer for the integer ALU path. Accepts one R-type
//   instruction at a time, registers its register/function fields, strobes
//   the ALU selector for one cycle and then waits for the ALU to finish.
//
//   States: IDLE (ready) -> SELECT (enable strobe) -> ISSUE (wait done).
//   Illegal words are rejected from IDLE with a one-cycle 'illegal' pulse.
//
//   Optional build macro: ALU_DISPATCH_TIMEOUT_EN
//     Adds the TIMEOUT parameter, a wait counter and the 'timeout' pulse;
//     ISSUE is abandoned after TIMEOUT cycles without alu_done.
//     Without it, ISSUE waits indefinitely.
// ---------------------------------------------------------------------------
module alu_dispatch
`ifdef ALU_DISPATCH_TIMEOUT_EN
#(
  parameter int TIMEOUT = 16
)
`endif
(
  input  logic           clock,
  input  logic           reset,
  alu_dispatch_if.master bus
);

  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] F7_BASE  = 7'd0;
  localparam logic [6:0] F7_ALT   = 7'd32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ISSUE  = 2'd2
  } state_t;

  // Only plain R-type integer ops (base and alternate funct7) go to this ALU.
  function automatic logic is_legal(input logic [31:0] word);
    logic [6:0] f7;
    f7 = word[31:25];
    return (word[6:0] == OPC_OP) && ((f7 == F7_BASE) || (f7 == F7_ALT));
  endfunction

  state_t      state_p1;
  state_t      state_nxt;

  logic        accept_p0;
  logic        legal_p0;
  logic        load_p0;
  logic        reject_p0;
  logic        done_p0;

  logic [6:0]  funct7_p1;
  logic [2:0]  funct3_p1;
  logic [4:0]  rs1_p1;
  logic [4:0]  rs2_p1;
  logic [4:0]  rd_p1;
  logic        illegal_p1;

  // A word is taken only while idle; anything offered in other states waits.
  assign accept_p0 = bus.instr_valid && (state_p1 == S_IDLE);
  assign legal_p0  = is_legal(bus.instr);
  assign load_p0   = accept_p0 && legal_p0;
  assign reject_p0 = accept_p0 && !legal_p0;

  // alu_done only matters while an operation is actually outstanding.
  assign done_p0   = (state_p1 == S_ISSUE) && bus.alu_done;

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wait_cnt_p1;
  logic             expire_p0;
  logic             timeout_p1;

  // Expiry fires in the TIMEOUT-th ISSUE cycle; a coincident alu_done wins.
  assign expire_p0 = (state_p1 == S_ISSUE) && !bus.alu_done &&
                     (wait_cnt_p1 == CNT_LAST);

  // Wait counter: cleared while strobing, counts ISSUE cycles without done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_p1 <= '0;
    end else if (state_p1 == S_SELECT) begin
      wait_cnt_p1 <= '0;
    end else if ((state_p1 == S_ISSUE) && !bus.alu_done) begin
      wait_cnt_p1 <= wait_cnt_p1 + CNT_W'(1);
    end
  end

  // One-cycle pulse after an abandoned wait.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_p1 <= 1'b0;
    end else begin
      timeout_p1 <= expire_p0;
    end
  end

  assign bus.timeout = timeout_p1;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_p1 <= S_IDLE;
    end else begin
      state_p1 <= state_nxt;
    end
  end

  // Next-state: illegal words leave the sequencer idle, SELECT lasts one cycle.
  always_comb begin
    state_nxt = state_p1;
    unique case (state_p1)
      S_IDLE: begin
        if (load_p0) begin
          state_nxt = S_SELECT;
        end
      end
      S_SELECT: begin
        state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (done_p0) begin
          state_nxt = S_IDLE;
        end
`ifdef ALU_DISPATCH_TIMEOUT_EN
        else if (expire_p0) begin
          state_nxt = S_IDLE;
        end
`endif
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Handshake and status outputs are pure functions of the current state.
  always_comb begin
    bus.instr_ready = 1'b0;
    bus.enable      = 1'b0;
    bus.issue_valid = 1'b0;
    bus.busy        = 1'b0;
    unique case (state_p1)
      S_IDLE: begin
        bus.instr_ready = 1'b1;
      end
      S_SELECT: begin
        bus.enable = 1'b1;
        bus.busy   = 1'b1;
      end
      S_ISSUE: begin
        bus.issue_valid = 1'b1;
        bus.busy        = 1'b1;
      end
      default: begin
        bus.instr_ready = 1'b0;
      end
    endcase
  end

  // Field registers: loaded only for legal words, held through SELECT/ISSUE
  // and kept afterwards so the selector sees stable values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      funct7_p1 <= '0;
      funct3_p1 <= '0;
      rs1_p1    <= '0;
      rs2_p1    <= '0;
      rd_p1     <= '0;
    end else if (load_p0) begin
      funct7_p1 <= bus.instr[31:25];
      funct3_p1 <= bus.instr[14:12];
      rs1_p1    <= bus.instr[19:15];
      rs2_p1    <= bus.instr[24:20];
      rd_p1     <= bus.instr[11:7];
    end
  end

  // One-cycle pulse for each rejected word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      illegal_p1 <= 1'b0;
    end else begin
      illegal_p1 <= reject_p0;
    end
  end

  assign bus.funct7  = funct7_p1;
  assign bus.funct3  = funct3_p1;
  assign bus.rs1     = rs1_p1;
  assign bus.rs2     = rs2_p1;
  assign bus.rd      = rd_p1;
  assign bus.illegal = illegal_p1;

endmodule

// File: tb/tb_alu_dispatch.sv
// ---------------------------------------------------------------------------
// tb_alu_dispatch
//   Directed sequence followed by random traffic, compared every cycle
//   against a cycle-age reference model of the dispatcher.
// ---------------------------------------------------------------------------
module tb_alu_dispatch;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  alu_dispatch_if bus ();

`ifdef ALU_DISPATCH_TIMEOUT_EN
  localparam int TMO = 4;
  alu_dispatch #(.TIMEOUT(TMO)) dut (.clock(clock), .reset(reset), .bus(bus));
`else
  alu_dispatch dut (.clock(clock), .reset(reset), .bus(bus));
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: an in-flight flag plus the age (cycles since accept).
  bit         m_busy;
  int         m_age;
  bit         m_ill;
  logic [6:0] m_f7;
  logic [2:0] m_f3;
  logic [4:0] m_rs1, m_rs2, m_rd;
`ifdef ALU_DISPATCH_TIMEOUT_EN
  bit         m_tmo;
`endif

  function automatic bit legal_word(input logic [31:0] w);
    int unsigned opc, f7;
    opc = w & 32'h7F;
    f7  = w >> 25;
    return (opc == 32'h33) && (f7 == 0 || f7 == 32);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_ill = 0;
    m_f7 = '0; m_f3 = '0; m_rs1 = '0; m_rs2 = '0; m_rd = '0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
    m_tmo = 0;
`endif
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_ready"},  bus.instr_ready, !m_busy);
    chk({tag, "_enable"}, bus.enable,      m_busy && m_age == 1);
    chk({tag, "_issue"},  bus.issue_valid, m_busy && m_age >= 2);
    chk({tag, "_busy"},   bus.busy,        m_busy);
    chk({tag, "_ill"},    bus.illegal,     m_ill);
    chk({tag, "_f7"},     bus.funct7,      m_f7);
    chk({tag, "_f3"},     bus.funct3,      m_f3);
    chk({tag, "_rs1"},    bus.rs1,         m_rs1);
    chk({tag, "_rs2"},    bus.rs2,         m_rs2);
    chk({tag, "_rd"},     bus.rd,          m_rd);
`ifdef ALU_DISPATCH_TIMEOUT_EN
    chk({tag, "_tmo"},    bus.timeout,     m_tmo);
`endif
  endtask

  // Advance the model by one edge using the current inputs, then clock the
  // DUT and compare all outputs one time unit after the edge.
  task automatic tick();
    logic [31:0] w;
    w = bus.instr;
    if (reset) begin
      model_reset();
    end else begin
      m_ill = 0;
`ifdef ALU_DISPATCH_TIMEOUT_EN
      m_tmo = 0;
`endif
      if (!m_busy) begin
        if (bus.instr_valid) begin
          if (legal_word(w)) begin
            m_busy = 1;
            m_age  = 1;
            m_f7   = 7'((w >> 25) & 32'h7F);
            m_f3   = 3'((w >> 12) & 32'h7);
            m_rs1  = 5'((w >> 15) & 32'h1F);
            m_rs2  = 5'((w >> 20) & 32'h1F);
            m_rd   = 5'((w >> 7)  & 32'h1F);
          end else begin
            m_ill = 1;
          end
        end
      end else if (m_age >= 2 && bus.alu_done) begin
        m_busy = 0;
      end
`ifdef ALU_DISPATCH_TIMEOUT_EN
      else if (m_age >= 2 && (m_age - 1) == TMO) begin
        m_busy = 0;
        m_tmo  = 1;
      end
`endif
      else begin
        m_age++;
      end
    end
    cyc++;
    @(posedge clock);
    #1;
    check_outputs($sformatf("c%0d", cyc));
  endtask

  initial begin
    int n_en;
    logic [31:0] w;

    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.alu_done    = 1'b0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    check_outputs("reset");
    reset = 1'b0;

    // ADD x1, x2, x3
    bus.instr = 32'h003100B3; bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    chk("add_enable", bus.enable, 1);
    chk("add_f7", bus.funct7, 0);
    chk("add_rs1", bus.rs1, 2);
    chk("add_rs2", bus.rs2, 3);
    chk("add_rd", bus.rd, 1);
    tick();
    chk("add_issue", bus.issue_valid, 1);
    bus.alu_done = 1'b1;
    tick();
    chk("add_idle", bus.instr_ready, 1);

    // SUB with valid and done held high: accepts every third cycle
    bus.instr = 32'h403100B3; bus.instr_valid = 1'b1;
    n_en = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) chk("sub_f7", bus.funct7, 32);
      if (bus.enable) n_en++;
    end
    chk("sub_enables", n_en, 2);
    bus.instr_valid = 1'b0; bus.alu_done = 1'b0;

    // MUL then ADDI back to back: both rejected, fields unchanged
    bus.instr = 32'h023100B3; bus.instr_valid = 1'b1;
    tick();
    chk("mul_ill", bus.illegal, 1);
    chk("mul_f7_kept", bus.funct7, 32);
    bus.instr = 32'h00510093;
    tick();
    chk("addi_ill", bus.illegal, 1);
    chk("addi_ready", bus.instr_ready, 1);
    bus.instr_valid = 1'b0;
    tick();

    // Different word offered during ISSUE is held off until completion
    bus.instr = 32'h003100B3; bus.instr_valid = 1'b1;
    tick();
    bus.instr = 32'h40628233;
    for (int i = 0; i < 4; i++) tick();
    chk("hold_rd", bus.rd, 1);
    bus.alu_done = 1'b1;
    tick();
    bus.alu_done = 1'b0;
    tick();
    chk("held_rd", bus.rd, 4);
    chk("held_f7", bus.funct7, 32);
    bus.instr_valid = 1'b0;
    bus.alu_done = 1'b1;
    tick();
    tick();
    bus.alu_done = 1'b0;

    // Asynchronous reset in the middle of ISSUE
    bus.instr = 32'h003100B3; bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("arst");
    bus.alu_done = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("arst_done_ignored", bus.enable, 0);
    bus.alu_done = 1'b0;
    tick();

`ifdef ALU_DISPATCH_TIMEOUT_EN
    // No completion: abandoned after TMO ISSUE cycles
    bus.instr = 32'h003100B3; bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    n_en = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus.timeout) n_en++;
    end
    chk("tmo_count", n_en, 1);
    // Completion on the last allowed ISSUE cycle: no timeout
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    bus.alu_done = 1'b1;
    tick();
    chk("tmo_done_wins", bus.timeout, 0);
    bus.alu_done = 1'b0;
    tick();
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0, 1: w = {($urandom_range(0, 1) != 0) ? 7'd32 : 7'd0, 18'($urandom), 7'h33};
        2:    w = {7'($urandom_range(1, 31)), 18'($urandom), 7'h33};
        default: w = $urandom;
      endcase
      bus.instr       = w;
      bus.instr_valid = ($urandom_range(0, 1) != 0);
      bus.alu_done    = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Issue-side sequencer for the integer ALU path: accepts one 32-bit R-type instruction at a time over a valid/ready handshake. It extracts the register and function fields and drives `enable` and `funct7` into the ALU selector for exactly one cycle. It then holds the operation issued until the ALU reports completion. It is the producer end of the selector's `enable`/`funct7` interface and sits between instruction fetch/decode and the ALU units.

## Interface
- `TIMEOUT`, default 16: maximum number of ISSUE cycles to wait for `alu_done`; must be ≥1 (used only with `ALU_DISPATCH_TIMEOUT_EN`).
- `clock` in 1: single clock, all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; forces the IDLE state and clears all outputs immediately.
- `instr_valid` in 1: upstream has an instruction on `instr`.
- `instr_ready` out 1: block can accept an instruction; high only in IDLE.
- `instr` in 32: RISC-V instruction word.
- `enable` out 1: selector strobe, high for exactly one cycle per legal instruction.
- `funct7` out 7: `instr[31:25]` of the accepted instruction.
- `funct3` out 3: `instr[14:12]`.
- `rs1`, `rs2`, `rd` out 5 each: `instr[19:15]`, `instr[24:20]`, `instr[11:7]`.
- `issue_valid` out 1: operation is issued to the ALU and awaiting completion.
- `alu_done` in 1: ALU completion; sampled only in ISSUE.
- `illegal` out 1: one-cycle pulse for a rejected instruction.
- `timeout` out 1: one-cycle pulse when a wait is abandoned (only present with `ALU_DISPATCH_TIMEOUT_EN`).
- `busy` out 1: high in SELECT and ISSUE.

## Operation
- States: IDLE, SELECT, ISSUE.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`&`instr_ready`, the instruction is accepted and decoded.
  - Legal means opcode `instr[6:0]`==7'b0110011 and `funct7` ∈ {0, 32}.
  - Legal: register all fields into the output registers, then go to SELECT.
  - Illegal: fields are not updated, `illegal` pulses next cycle, and the state stays IDLE.
- SELECT:
  - `enable`=1 for this single cycle.
  - `funct7` is already stable from the previous edge.
  - Unconditional transition to ISSUE.
- ISSUE:
  - `issue_valid`=1.
  - `alu_done`=1 → IDLE.
- `funct7`/`funct3`/`rs1`/`rs2`/`rd` hold from SELECT through the end of ISSUE and keep their last value in IDLE.
- `alu_done` in IDLE or SELECT is ignored.
- `instr_valid` while not ready is ignored; upstream holds the instruction.
- Reset values: all outputs 0 except `instr_ready`=1 (reflects IDLE); internal counter 0.
- Reset mid-operation: the in-flight instruction is dropped, with no `illegal`/`timeout` pulse.

## Timing
- Legal instruction accepted at edge N:
  - `enable`=1 during cycle N+1.
  - `issue_valid`=1 from cycle N+2.
- `alu_done` sampled high at edge M in ISSUE: `issue_valid`=0 and `instr_ready`=1 after edge M.
- Minimum accept-to-accept spacing is 3 cycles (`alu_done` already high in the first ISSUE cycle).
- Illegal accepted at edge N: `illegal`=1 during cycle N+1; `instr_ready` stays 1, so back-to-back accepts are possible.
- Exactly one `enable` pulse per legal instruction; never two in consecutive cycles.

## Configuration
- `ALU_DISPATCH_TIMEOUT_EN` defined:
  - A `$clog2(TIMEOUT+1)`-bit counter clears on entry to ISSUE and increments each ISSUE cycle without `alu_done`.
  - If `alu_done` has not been seen when the counter reaches `TIMEOUT`, `timeout` pulses one cycle and the state returns to IDLE.
  - If `alu_done` and expiry coincide, `alu_done` wins and there is no `timeout` pulse.
- `ALU_DISPATCH_TIMEOUT_EN` not defined: no counter and no `timeout` port; ISSUE waits indefinitely for `alu_done`.

## Test plan
- Reset: assert `reset` mid-ISSUE → outputs 0 and `instr_ready`=1 without waiting for a clock edge; a later `alu_done` has no effect.
- ADD 0x003100B3 accepted:
  - Cycle after acceptance: `enable`=1, `funct7`=0, `rs1`=2, `rs2`=3, `rd`=1.
  - Next cycle: `issue_valid`=1.
  - `alu_done` one cycle later → IDLE.
- SUB 0x403100B3 → `funct7`=32 and a single `enable` pulse; `alu_done` held high continuously gives a 3-cycle accept-to-accept spacing.
- 0x023100B3 (MUL, `funct7`=1), then ADDI 0x00510093:
  - Each gives an `illegal` pulse, no `enable`, and unchanged fields.
  - Back-to-back accepts.
- `instr_valid` held during ISSUE with a different word → not accepted; fields unchanged until `alu_done`, then accepted in IDLE.
- With `ALU_DISPATCH_TIMEOUT_EN`, `TIMEOUT`=4:
  - No `alu_done` → `timeout` pulse after 4 ISSUE cycles, then IDLE.
  - `alu_done` on the 4th ISSUE cycle → no `timeout`.
